// File: rtl/tpuv2.sv
// tpuv2: memory-mapped signed matrix-multiply unit, C = A*B or C += A*B.
// The host loads A and B (and optionally C) over a word bus, writes CTRL to
// start, polls or waits for done, then reads C back. Compute is
// row-sequential: DIM MACs work on one row of C, one k per cycle.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset, clears state and all storage
//   r_w        1 = write dataIn to addr this cycle, 0 = read
//   addr       byte address
//   dataIn     write data
//   dataOut    read data, combinational from addr and current storage
//   busy       high while computing
//   done       sticky completion flag
//   done_pulse one-cycle completion strobe
//
// state | meaning
// IDLE  | bus writes to A/B/C/CTRL accepted, waiting for start
// RUN   | one cycle per (row i, k), k fastest; row i of C written at k=DIM-1
module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int SAT     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_w,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             done_pulse
);

    localparam int S         = DATAW / 8;
    localparam int WA        = DIM * BITS_AB / DATAW;
    localparam int WC        = DIM * BITS_C / DATAW;
    localparam int ROWA      = DIM * BITS_AB;
    localparam int ROWC      = DIM * BITS_C;
    localparam int PW        = 2 * BITS_AB;
    localparam int ACCW      = 2 * BITS_AB + $clog2(DIM) + BITS_C + 1;
    localparam int IW        = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int A_BASE    = 'h100;
    localparam int B_BASE    = 'h200;
    localparam int C_BASE    = 'h300;
    localparam int CTRL_ADDR = 'h400;

    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    localparam logic signed [ACCW-1:0] C_MAX = {{(ACCW-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
    localparam logic signed [ACCW-1:0] C_MIN = {{(ACCW-BITS_C+1){1'b1}}, {(BITS_C-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    logic   mode;
    logic [IW-1:0] row_i;
    logic [IW-1:0] col_k;

    logic [ROWA-1:0] a_mem [DIM];
    logic [ROWA-1:0] b_mem [DIM];
    logic [ROWC-1:0] c_mem [DIM];
    logic signed [ACCW-1:0] acc [DIM];

    // ---------------------------------------------------------------
    // Address decode: word index relative to each region base.
    // ---------------------------------------------------------------
    int   addr_i, a_idx, b_idx, c_idx;
    logic a_hit, b_hit, c_hit, ctrl_hit;

    always_comb begin
        addr_i   = int'(addr);
        a_idx    = (addr_i - A_BASE) / S;
        b_idx    = (addr_i - B_BASE) / S;
        c_idx    = (addr_i - C_BASE) / S;
        a_hit    = (addr_i % S == 0) && (addr_i >= A_BASE) && (addr_i < A_BASE + DIM * WA * S);
        b_hit    = (addr_i % S == 0) && (addr_i >= B_BASE) && (addr_i < B_BASE + DIM * WA * S);
        c_hit    = (addr_i % S == 0) && (addr_i >= C_BASE) && (addr_i < C_BASE + DIM * WC * S);
        ctrl_hit = (addr_i == CTRL_ADDR);
    end

    always_comb begin
        dataOut = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int w = 0; w < WA; w++) begin
                if (a_hit && a_idx == r * WA + w) dataOut = a_mem[r][w*DATAW +: DATAW];
                if (b_hit && b_idx == r * WA + w) dataOut = b_mem[r][w*DATAW +: DATAW];
            end
            for (int w = 0; w < WC; w++) begin
                if (c_hit && c_idx == r * WC + w) dataOut = c_mem[r][w*DATAW +: DATAW];
            end
        end
        if (ctrl_hit) dataOut = DATAW'({mode, done, busy});
    end

    // ---------------------------------------------------------------
    // MAC datapath: A[i][k] broadcast against row k of B.
    // ---------------------------------------------------------------
    logic [ROWA-1:0]        a_row_sel, b_row_sel;
    logic [ROWC-1:0]        c_row_sel, c_row_nxt;
    logic signed [BITS_AB-1:0] a_elem, b_elem;
    logic signed [BITS_C-1:0]  c_elem;
    logic signed [PW-1:0]      prod;
    logic signed [ACCW-1:0]    base;
    logic signed [ACCW-1:0]    acc_nxt [DIM];

    always_comb begin
        a_row_sel = '0;
        b_row_sel = '0;
        c_row_sel = '0;
        c_row_nxt = '0;
        a_elem    = '0;
        b_elem    = '0;
        c_elem    = '0;
        prod      = '0;
        base      = '0;
        for (int r = 0; r < DIM; r++) begin
            acc_nxt[r] = '0;
            if (r == int'(row_i)) begin
                a_row_sel = a_mem[r];
                c_row_sel = c_mem[r];
            end
            if (r == int'(col_k)) b_row_sel = b_mem[r];
        end
        for (int e = 0; e < DIM; e++) begin
            if (e == int'(col_k)) a_elem = a_row_sel[e*BITS_AB +: BITS_AB];
        end
        for (int j = 0; j < DIM; j++) begin
            b_elem = b_row_sel[j*BITS_AB +: BITS_AB];
            c_elem = c_row_sel[j*BITS_C +: BITS_C];
            prod   = PW'(a_elem) * PW'(b_elem);
            if (col_k == '0) begin
                base = mode ? ACCW'(c_elem) : '0;
            end else begin
                base = acc[j];
            end
            acc_nxt[j] = base + ACCW'(prod);
            if (SAT != 0 && acc_nxt[j] > C_MAX) begin
                c_row_nxt[j*BITS_C +: BITS_C] = C_MAX[BITS_C-1:0];
            end else if (SAT != 0 && acc_nxt[j] < C_MIN) begin
                c_row_nxt[j*BITS_C +: BITS_C] = C_MIN[BITS_C-1:0];
            end else begin
                c_row_nxt[j*BITS_C +: BITS_C] = acc_nxt[j][BITS_C-1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Control FSM and storage
    // ---------------------------------------------------------------
    logic ctrl_wr;
    assign ctrl_wr = r_w && ctrl_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            mode       <= 1'b0;
            row_i      <= '0;
            col_k      <= '0;
            for (int r = 0; r < DIM; r++) begin
                a_mem[r] <= '0;
                b_mem[r] <= '0;
                c_mem[r] <= '0;
                acc[r]   <= '0;
            end
        end else begin
            done_pulse <= 1'b0;
            // done_clr works in both states; a start or completion below overrides it
            if (ctrl_wr && dataIn[2]) done <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_w) begin
                        for (int r = 0; r < DIM; r++) begin
                            for (int w = 0; w < WA; w++) begin
                                if (a_hit && a_idx == r * WA + w) a_mem[r][w*DATAW +: DATAW] <= dataIn;
                                if (b_hit && b_idx == r * WA + w) b_mem[r][w*DATAW +: DATAW] <= dataIn;
                            end
                            for (int w = 0; w < WC; w++) begin
                                if (c_hit && c_idx == r * WC + w) c_mem[r][w*DATAW +: DATAW] <= dataIn;
                            end
                        end
                    end
                    if (ctrl_wr && dataIn[0]) begin
                        mode  <= dataIn[1];
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        row_i <= '0;
                        col_k <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < DIM; j++) acc[j] <= acc_nxt[j];
                    if (col_k == LAST) begin
                        for (int r = 0; r < DIM; r++) begin
                            if (r == int'(row_i)) c_mem[r] <= c_row_nxt;
                        end
                        col_k <= '0;
                        if (row_i == LAST) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            done_pulse <= 1'b1;
                        end else begin
                            row_i <= row_i + 1'b1;
                        end
                    end else begin
                        col_k <= col_k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpuv2.sv
// Testbench for tpuv2: two instances (saturating and wrapping) share one bus
// and are checked against a plain-arithmetic matrix model.
module tb_tpuv2;
    localparam int DIM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] addr = '0;
    logic [63:0] dataIn = '0;
    logic [63:0] dout_s, dout_w;
    logic        busy_s, busy_w, done_s, done_w, pulse_s, pulse_w;

    tpuv2 #(.SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .r_w(r_w), .addr(addr), .dataIn(dataIn),
        .dataOut(dout_s), .busy(busy_s), .done(done_s), .done_pulse(pulse_s)
    );
    tpuv2 #(.SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .r_w(r_w), .addr(addr), .dataIn(dataIn),
        .dataOut(dout_w), .busy(busy_w), .done(done_w), .done_pulse(pulse_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_len_s = 0, busy_len_w = 0, pulse_len_s = 0, pulse_len_w = 0;

    always @(negedge clk) begin
        if (busy_s) busy_len_s++;
        if (busy_w) busy_len_w++;
        if (pulse_s) pulse_len_s++;
        if (pulse_w) pulse_len_w++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int ma [DIM][DIM];
    int mb [DIM][DIM];
    int mcs[DIM][DIM];
    int mcw[DIM][DIM];
    int m_mode = 0;
    int m_done = 0;

    function automatic int wrap16(input longint v);
        longint t;
        t = v % 65536;
        if (t < 0) t += 65536;
        if (t >= 32768) t -= 65536;
        return int'(t);
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = 0; mb[i][j] = 0; mcs[i][j] = 0; mcw[i][j] = 0;
            end
        m_mode = 0;
        m_done = 0;
    endtask

    task automatic model_compute(input int acc);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                longint ss, sw, p;
                ss = (acc != 0) ? longint'(mcs[i][j]) : 0;
                sw = (acc != 0) ? longint'(mcw[i][j]) : 0;
                for (int k = 0; k < DIM; k++) begin
                    p = longint'(ma[i][k]) * longint'(mb[k][j]);
                    ss += p;
                    sw += p;
                end
                mcs[i][j] = clamp16(ss);
                mcw[i][j] = wrap16(sw);
            end
        m_mode = acc;
        m_done = 1;
    endtask

    function automatic logic [63:0] ab_word(input int which, input int r);
        logic [63:0] w;
        w = '0;
        for (int e = 0; e < DIM; e++) w[e*8 +: 8] = 8'((which == 0) ? ma[r][e] : mb[r][e]);
        return w;
    endfunction

    function automatic logic [63:0] c_word(input int sat, input int r, input int wd);
        logic [63:0] w;
        w = '0;
        for (int e = 0; e < 4; e++) w[e*16 +: 16] = 16'((sat != 0) ? mcs[r][wd*4+e] : mcw[r][wd*4+e]);
        return w;
    endfunction

    function automatic logic [63:0] status_exp();
        return 64'(m_mode * 4 + m_done * 2);
    endfunction

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        r_w = 1'b1; addr = a; dataIn = d;
        @(posedge clk);
        #1 r_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] ds, output logic [63:0] dw);
        @(negedge clk);
        r_w = 1'b0; addr = a;
        #1;
        ds = dout_s;
        dw = dout_w;
    endtask

    task automatic load_ab();
        for (int r = 0; r < DIM; r++) begin
            wr(16'(16'h100 + r * 8), ab_word(0, r));
            wr(16'(16'h200 + r * 8), ab_word(1, r));
        end
    endtask

    task automatic load_c();
        for (int r = 0; r < DIM; r++)
            for (int wd = 0; wd < 2; wd++) wr(16'(16'h300 + (r * 2 + wd) * 8), c_word(1, r, wd));
    endtask

    task automatic set_ident_pattern();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = r * 8 + c;
            end
    endtask

    task automatic do_start(input int acc, input int clr);
        busy_len_s = 0; busy_len_w = 0; pulse_len_s = 0; pulse_len_w = 0;
        model_compute(acc);
        wr(16'h400, 64'(clr * 4 + acc * 2 + 1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy_s || busy_w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_done busy still high after %0d cycles, required low", n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] ds, dw;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (busy_s !== 1'b0 || busy_w !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b required 0", busy_s, busy_w); end
        checks++; if (done_s !== 1'b0 || done_w !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b required 0", done_s, done_w); end
        checks++; if (pulse_s !== 1'b0 || pulse_w !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b/%b required 0", pulse_s, pulse_w); end
        rd(16'h400, ds, dw);
        checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL reset_status got %h/%h required 0", ds, dw); end
        for (int a = 16'h300; a < 16'h380; a += 8) begin
            rd(16'(a), ds, dw);
            checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL reset_c addr %h got %h/%h required 0", a, ds, dw); end
        end
    endtask

    task automatic test_identity();
        logic [63:0] ds, dw;
        set_ident_pattern();
        load_ab();
        do_start(0, 0);
        wait_done();
        checks++; if (busy_len_s != 64 || busy_len_w != 64) begin errors++; $display("FAIL ident_busy_len got %0d/%0d required 64", busy_len_s, busy_len_w); end
        checks++; if (pulse_len_s != 1 || pulse_len_w != 1) begin errors++; $display("FAIL ident_pulse_len got %0d/%0d required 1", pulse_len_s, pulse_len_w); end
        checks++; if (done_s !== 1'b1 || done_w !== 1'b1) begin errors++; $display("FAIL ident_done got %b/%b required 1", done_s, done_w); end
        for (int r = 0; r < DIM; r++)
            for (int wd = 0; wd < 2; wd++) begin
                rd(16'(16'h300 + (r * 2 + wd) * 8), ds, dw);
                checks++; if (ds !== c_word(1, r, wd)) begin errors++; $display("FAIL ident_c_sat r%0d w%0d got %h required %h", r, wd, ds, c_word(1, r, wd)); end
                checks++; if (dw !== c_word(0, r, wd)) begin errors++; $display("FAIL ident_c_wrap r%0d w%0d got %h required %h", r, wd, dw, c_word(0, r, wd)); end
            end
        rd(16'h400, ds, dw);
        checks++; if (ds !== status_exp() || dw !== status_exp()) begin errors++; $display("FAIL ident_status got %h/%h required %h", ds, dw, status_exp()); end
    endtask

    task automatic test_accumulate();
        logic [63:0] ds, dw;
        do_start(1, 0);
        wait_done();
        for (int r = 0; r < DIM; r++)
            for (int wd = 0; wd < 2; wd++) begin
                rd(16'(16'h300 + (r * 2 + wd) * 8), ds, dw);
                checks++; if (ds !== c_word(1, r, wd) || dw !== c_word(0, r, wd)) begin errors++; $display("FAIL acc_c r%0d w%0d got %h/%h required %h/%h", r, wd, ds, dw, c_word(1, r, wd), c_word(0, r, wd)); end
            end
        rd(16'h400, ds, dw);
        checks++; if (ds !== status_exp() || dw !== status_exp()) begin errors++; $display("FAIL acc_status got %h/%h required %h", ds, dw, status_exp()); end
        wr(16'h400, 64'h4);
        m_done = 0;
        rd(16'h400, ds, dw);
        checks++; if (ds !== status_exp() || dw !== status_exp()) begin errors++; $display("FAIL acc_status_clr got %h/%h required %h", ds, dw, status_exp()); end
    endtask

    task automatic test_saturation();
        logic [63:0] ds, dw;
        for (int pat = 0; pat < 2; pat++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    ma[r][c] = (pat == 0) ? 127 : -128;
                    mb[r][c] = 127;
                end
            load_ab();
            do_start(0, 0);
            wait_done();
            for (int r = 0; r < DIM; r++)
                for (int wd = 0; wd < 2; wd++) begin
                    rd(16'(16'h300 + (r * 2 + wd) * 8), ds, dw);
                    checks++; if (ds !== c_word(1, r, wd)) begin errors++; $display("FAIL sat_c p%0d r%0d w%0d got %h required %h", pat, r, wd, ds, c_word(1, r, wd)); end
                    checks++; if (dw !== c_word(0, r, wd)) begin errors++; $display("FAIL wrap_c p%0d r%0d w%0d got %h required %h", pat, r, wd, dw, c_word(0, r, wd)); end
                end
        end
    endtask

    task automatic test_busy_writes();
        logic [63:0] ds, dw;
        set_ident_pattern();
        load_ab();
        do_start(0, 0);
        wr(16'h138, 64'h0);
        wr(16'h200, 64'h0);
        wr(16'h370, 64'h1234);
        wr(16'h400, 64'h1);
        wr(16'h400, 64'h3);
        rd(16'h100, ds, dw);
        checks++; if (ds !== ab_word(0, 0) || dw !== ab_word(0, 0)) begin errors++; $display("FAIL busy_read_a got %h/%h required %h", ds, dw, ab_word(0, 0)); end
        wait_done();
        checks++; if (busy_len_s != 64 || busy_len_w != 64) begin errors++; $display("FAIL busy_wr_len got %0d/%0d required 64", busy_len_s, busy_len_w); end
        rd(16'h238, ds, dw);
        checks++; if (ds !== ab_word(1, 7)) begin errors++; $display("FAIL busy_wr_b7 got %h required %h", ds, ab_word(1, 7)); end
        for (int r = 0; r < DIM; r++)
            for (int wd = 0; wd < 2; wd++) begin
                rd(16'(16'h300 + (r * 2 + wd) * 8), ds, dw);
                checks++; if (ds !== c_word(1, r, wd) || dw !== c_word(0, r, wd)) begin errors++; $display("FAIL busy_wr_c r%0d w%0d got %h/%h required %h", r, wd, ds, dw, c_word(1, r, wd)); end
            end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] ds, dw;
        set_ident_pattern();
        load_ab();
        do_start(0, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (busy_s !== 1'b0 || busy_w !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b/%b required 0", busy_s, busy_w); end
        checks++; if (done_s !== 1'b0 || done_w !== 1'b0) begin errors++; $display("FAIL midrst_done got %b/%b required 0", done_s, done_w); end
        for (int r = 0; r < DIM; r++) begin
            rd(16'(16'h100 + r * 8), ds, dw);
            checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL midrst_a r%0d got %h/%h required 0", r, ds, dw); end
            rd(16'(16'h200 + r * 8), ds, dw);
            checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL midrst_b r%0d got %h/%h required 0", r, ds, dw); end
            rd(16'(16'h300 + r * 16), ds, dw);
            checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL midrst_c r%0d got %h/%h required 0", r, ds, dw); end
        end
        test_identity();
    endtask

    task automatic test_addr();
        logic [63:0] ds, dw;
        logic [15:0] unm [6];
        unm = '{16'h000, 16'h0F8, 16'h140, 16'h240, 16'h380, 16'h408};
        wr(16'h140, 64'hDEAD_BEEF_0000_0001);
        wr(16'h380, 64'hDEAD_BEEF_0000_0002);
        for (int n = 0; n < 6; n++) begin
            rd(unm[n], ds, dw);
            checks++; if (ds !== 64'h0 || dw !== 64'h0) begin errors++; $display("FAIL unmapped addr %h got %h/%h required 0", unm[n], ds, dw); end
        end
        rd(16'h300, ds, dw);
        checks++; if (ds !== c_word(1, 0, 0)) begin errors++; $display("FAIL unmapped_alias got %h required %h", ds, c_word(1, 0, 0)); end
    endtask

    task automatic test_random();
        logic [63:0] ds, dw;
        int acc, clr, v;
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    ma[r][c] = int'($urandom_range(0, 255)) - 128;
                    mb[r][c] = int'($urandom_range(0, 255)) - 128;
                    v = int'($urandom_range(0, 65535)) - 32768;
                    mcs[r][c] = v;
                    mcw[r][c] = v;
                end
            load_ab();
            load_c();
            acc = int'($urandom_range(0, 1));
            clr = int'($urandom_range(0, 1));
            do_start(acc, clr);
            wait_done();
            for (int r = 0; r < DIM; r++)
                for (int wd = 0; wd < 2; wd++) begin
                    rd(16'(16'h300 + (r * 2 + wd) * 8), ds, dw);
                    checks++; if (ds !== c_word(1, r, wd)) begin errors++; $display("FAIL rand_c_sat it%0d r%0d w%0d got %h required %h", it, r, wd, ds, c_word(1, r, wd)); end
                    checks++; if (dw !== c_word(0, r, wd)) begin errors++; $display("FAIL rand_c_wrap it%0d r%0d w%0d got %h required %h", it, r, wd, dw, c_word(0, r, wd)); end
                end
            rd(16'h400, ds, dw);
            checks++; if (ds !== status_exp() || dw !== status_exp()) begin errors++; $display("FAIL rand_status it%0d got %h/%h required %h", it, ds, dw, status_exp()); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_accumulate();
        test_saturation();
        test_busy_writes();
        test_reset_midrun();
        test_addr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
